pll_clk_div_gen: RTL
====================

# pll_clk_div_gen

Multi-channel clock-enable and divided-clock generator that sits directly behind the PLL wrapper, on its output clock. It filters the PLL `locked` flag, produces a lock-qualified system reset, and drives NUM_CH independently programmable divided clocks and clock-enable strobes. Each channel has its own runtime divide, duty and phase settings, and all channels can be phase-aligned on command. This replaces fixed-frequency PLL taps for slow peripherals and the CPU pipeline clock enable.

## Interface
- NUM_CH, 4: number of output channels (1..16)
- CNT_W, 16: width of divide, high-time and phase fields
- LOCK_FILTER, 256: consecutive synchronized-lock cycles required before `locked_out` asserts (≥1)
- DEF_DIV, 4: reset value of every channel's divide ratio
- refclk  in  1  clock (PLL output clock)
- rst  in  1  asynchronous, active-high reset
- pll_locked  in  1  raw PLL lock flag, asynchronous to refclk
- cfg_we  in  1  config write strobe
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel
- cfg_div  in  CNT_W  period N in refclk cycles
- cfg_high  in  CNT_W  high time H of div_clk
- cfg_phase  in  CNT_W  phase delay P
- cfg_sync  in  1  one-cycle pulse: realign all channels
- locked_out  out  1  filtered lock
- rst_out  out  1  active-high system reset, equal to ~locked_out
- clk_en  out  NUM_CH  one-cycle strobe per period, per channel
- div_clk  out  NUM_CH  registered divided clock, per channel

## Operation
- Lock path:
  - pll_locked passes through a 2-flop synchronizer into a filter counter.
  - The counter increments while the synchronized lock is 1, saturating at LOCK_FILTER; `locked_out`=1 when it reaches LOCK_FILTER.
  - Any synchronized 0 clears the counter and `locked_out` at once.
- Channel state: active regs (N, H, P), shadow regs, and counter `cnt`.
  - Effective N = max(cfg N, 1).
  - H is clamped to [1, N−1] for N≥2.
  - P is clamped to N−1.
- Channel states:
  - IDLE: `locked_out`=0, cnt held, outputs 0.
  - RUN: `locked_out`=1.
  - IDLE→RUN loads active from shadow and sets cnt = (P==0 ? 0 : N−P).
  - RUN→IDLE on lock loss.
- RUN behaviour:
  - cnt advances each cycle and wraps N−1→0.
  - clk_en=1 while cnt==0.
  - div_clk=1 while cnt<H.
  - N=1: clk_en and div_clk are constantly 1.
- cfg_we writes shadow of cfg_ch. cfg_ch ≥ NUM_CH is ignored.
- Shadow→active transfer:
  - In RUN, only at the period boundary (cnt==N−1), so there are no runt pulses.
  - In IDLE, immediately.
- cfg_sync: every RUN channel loads shadow→active and reloads cnt per P on the next cycle. This overrides the boundary transfer.
- Write + sync in the same cycle: the sync uses the newly written value.
- Reset: shadow and active = (DEF_DIV, DEF_DIV/2, 0), cnt=0, filter=0, `locked_out`=0, `rst_out`=1, clk_en=0, div_clk=0.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- pll_locked rise → `locked_out` rise after 2+LOCK_FILTER cycles, provided the lock stays stable.
- pll_locked fall → `locked_out` fall 3 cycles later.
- Channel outputs go to 0 in the same cycle `locked_out` falls.
- First RUN cycle is the cycle after `locked_out` rises:
  - P=0: clk_en asserts in that cycle.
  - Otherwise clk_en asserts P cycles later.
- cfg_we → shadow visible the next cycle.
- cfg_sync asserted in cycle t → realigned cnt in cycle t+1. With P=0, clk_en=1 in t+1 for all channels simultaneously.
- `rst` mid-operation: everything returns to its reset value asynchronously, and the lock filter restarts from 0.

## Structure
- Package `pll_clk_pkg`:
  - channel config struct {div, high, phase}
  - CNT_W default and DEF_DIV
  - clamp function for H and P
- Sub-module `pll_clk_div_chan`:
  - one channel: shadow/active regs, counter, clamp, output decode
  - instantiated NUM_CH times by a generate loop
- Top level holds the synchronizer, lock filter, config demux and the sync fan-out.

## Test plan
- Reset, then pll_locked=1 with LOCK_FILTER=8 → `locked_out` rises exactly 10 cycles later; `rst_out` falls in the same cycle.
- Lock glitch: pll_locked low for 1 cycle at filter count 5 → filter clears; `locked_out` rises only 10 cycles after pll_locked returns high.
- Channel 0 with N=5, H=2, P=0 → clk_en every 5 cycles; div_clk pattern 11000 repeating; first pulse in the first RUN cycle.
- Channel 1 with N=6, P=2, then cfg_sync → clk_en first asserts 2 cycles after the realignment cycle, and every 6 cycles thereafter.
- Write N=3 to a running channel mid-period → old period completes; new 3-cycle period starts at the boundary; no short pulse.
- Edge values:
  - N=0 or N=1 → clk_en and div_clk constant 1.
  - H=N, with N=4 → H clamped to 3, div_clk 1110.
  - cfg_ch=NUM_CH → no state change in any channel.

Source files
------------

// File: rtl/pll_clk_pkg.sv
// pll_clk_pkg: shared channel config type, reset defaults and the config clamp helper
package pll_clk_pkg;

    localparam int CNT_WIDTH   = 16;
    localparam int DEFAULT_DIV = 4;

    typedef struct packed {
        logic [CNT_WIDTH-1:0] div;
        logic [CNT_WIDTH-1:0] high;
        logic [CNT_WIDTH-1:0] phase;
    } chan_cfg_t;

    // Effective config: N >= 1, H in [1, N-1] (1 when N == 1), P <= N-1
    function automatic chan_cfg_t clamp_cfg(chan_cfg_t c);
        chan_cfg_t e;
        e.div   = (c.div == '0) ? CNT_WIDTH'(1) : c.div;
        e.high  = (e.div < CNT_WIDTH'(2) || c.high == '0) ? CNT_WIDTH'(1) :
                  (c.high >= e.div) ? e.div - CNT_WIDTH'(1) : c.high;
        e.phase = (c.phase >= e.div) ? e.div - CNT_WIDTH'(1) : c.phase;
        return e;
    endfunction

endpackage

// File: rtl/pll_clk_div_chan.sv
// pll_clk_div_chan: one divided-clock channel with shadow/active config, period counter and registered decode
module pll_clk_div_chan
    import pll_clk_pkg::*;
#(
    parameter int DEF_DIV = DEFAULT_DIV
) (
    input  logic      refclk,
    input  logic      rst,
    input  logic      en,
    input  logic      we,
    input  logic      sync,
    input  chan_cfg_t cfg,
    output logic      clk_en,
    output logic      div_clk
);

    localparam chan_cfg_t RST_CFG = '{div: CNT_WIDTH'(DEF_DIV), high: CNT_WIDTH'(DEF_DIV / 2), phase: '0};
    localparam chan_cfg_t RST_ACT = clamp_cfg(RST_CFG);

    chan_cfg_t            shadow, active, shadow_n, load, nxt;
    logic                 run;
    logic [CNT_WIDTH-1:0] cnt, cnt_n;

    // Next active config and counter: (re)align on start or sync, swap config only at the period boundary
    always_comb begin
        shadow_n = we ? cfg : shadow;
        load     = clamp_cfg(shadow_n);
        nxt      = active;
        cnt_n    = cnt + CNT_WIDTH'(1);
        if (!run || sync) begin
            nxt   = load;
            cnt_n = (load.phase == '0) ? '0 : load.div - load.phase;
        end else if (cnt == active.div - CNT_WIDTH'(1)) begin
            nxt   = load;
            cnt_n = '0;
        end
    end

    // Channel state and registered outputs; idle channels track the shadow and hold their counter
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            shadow  <= RST_CFG;
            active  <= RST_ACT;
            run     <= 1'b0;
            cnt     <= '0;
            clk_en  <= 1'b0;
            div_clk <= 1'b0;
        end else begin
            shadow <= shadow_n;
            if (!en) begin
                run     <= 1'b0;
                active  <= load;
                clk_en  <= 1'b0;
                div_clk <= 1'b0;
            end else begin
                run     <= 1'b1;
                active  <= nxt;
                cnt     <= cnt_n;
                clk_en  <= (cnt_n == '0);
                div_clk <= (cnt_n < nxt.high);
            end
        end
    end

endmodule

// File: rtl/pll_clk_div_gen.sv
// pll_clk_div_gen: PLL lock filter, lock-qualified reset and NUM_CH programmable divided clocks
module pll_clk_div_gen
    import pll_clk_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = CNT_WIDTH,
    parameter int LOCK_FILTER = 256,
    parameter int DEF_DIV     = DEFAULT_DIV,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_high,
    input  logic [CNT_W-1:0]  cfg_phase,
    input  logic              cfg_sync,
    output logic              locked_out,
    output logic              rst_out,
    output logic [NUM_CH-1:0] clk_en,
    output logic [NUM_CH-1:0] div_clk
);

    localparam int FW = $clog2(LOCK_FILTER + 1);

    logic          sync1, sync2, lock_next;
    logic [FW-1:0] filt, filt_next;
    chan_cfg_t     cfg;

    assign cfg = '{div: CNT_WIDTH'(cfg_div), high: CNT_WIDTH'(cfg_high), phase: CNT_WIDTH'(cfg_phase)};

    // Saturating run-length of synchronized lock; lock_next lets channels drop in the same cycle as locked_out
    always_comb begin
        filt_next = !sync2 ? '0 : (filt == FW'(LOCK_FILTER)) ? filt : filt + FW'(1);
        lock_next = (filt_next == FW'(LOCK_FILTER));
    end

    // Lock synchronizer, filter counter and registered lock/reset outputs
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            filt       <= '0;
            locked_out <= 1'b0;
            rst_out    <= 1'b1;
        end else begin
            sync1      <= pll_locked;
            sync2      <= sync1;
            filt       <= filt_next;
            locked_out <= lock_next;
            rst_out    <= !lock_next;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pll_clk_div_chan #(.DEF_DIV(DEF_DIV)) u_chan (
            .refclk  (refclk),
            .rst     (rst),
            .en      (locked_out & lock_next),
            .we      (cfg_we && cfg_ch == CH_W'(g)),
            .sync    (cfg_sync),
            .cfg     (cfg),
            .clk_en  (clk_en[g]),
            .div_clk (div_clk[g])
        );
    end

endmodule
